// File: rtl/wb_snoop_responder_pkg.sv
// Shared definitions for the snoop responder and the snoop arbiter.
// Provides:
//   - snoop bus type encodings (IDLE / READ)
//   - one-hot FSM state encodings used by the responder
//   - poll response codes shared with wb_snoop_arbiter
package wb_snoop_responder_pkg;

    localparam logic SNOOP_TYPE_IDLE = 1'b0;
    localparam logic SNOOP_TYPE_READ = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'b001;
    localparam state_t ST_LOOKUP  = 3'b010;
    localparam state_t ST_RESPOND = 3'b100;

    localparam logic [1:0] POLL_RESPONSE_NONE = 2'd0;
    localparam logic [1:0] POLL_RESPONSE_MISS = 2'd1;
    localparam logic [1:0] POLL_RESPONSE_HIT  = 2'd2;

endpackage

// File: rtl/wb_snoop_responder_if.sv
// Snoop bus slice between wb_snoop_arbiter (master) and one per-core
// wb_snoop_responder (slave). Signal suffixes are from the responder's view.
//   snoop_adr_i       : probe address
//   snoop_type_i      : 0 = idle, 1 = read probe
//   snoop_ack_o       : response ready (level)
//   snoop_valid_dat_o : probe hit, snooped_dat_o carries the line
//   snooped_dat_o     : hit data, 0 otherwise
interface wb_snoop_responder_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic [aw-1:0] snoop_adr_i;
    logic          snoop_type_i;
    logic          snoop_ack_o;
    logic          snoop_valid_dat_o;
    logic [dw-1:0] snooped_dat_o;

    modport master (
        output snoop_adr_i,
        output snoop_type_i,
        input  snoop_ack_o,
        input  snoop_valid_dat_o,
        input  snooped_dat_o
    );

    modport slave (
        input  snoop_adr_i,
        input  snoop_type_i,
        output snoop_ack_o,
        output snoop_valid_dat_o,
        output snooped_dat_o
    );
endinterface

// File: rtl/wb_snoop_responder_tag_store.sv
// Direct-mapped valid/tag/data store for the snoop responder.
// Ports:
//   wb_clk_i, wb_rst_i   : clock, sync active-high reset (clears valid bits only)
//   fill_*               : write port, makes entry[fill_idx_i] valid with new tag/data
//   inv_*                : clears entry[inv_idx_i] when its stored tag matches
//   rd_idx_i / rd_*_o    : combinational read port
module wb_snoop_responder_tag_store #(
    parameter int idx_bits = 3,
    parameter int tag_w    = 27,
    parameter int dw       = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                fill_we_i,
    input  logic [idx_bits-1:0] fill_idx_i,
    input  logic [tag_w-1:0]    fill_tag_i,
    input  logic [dw-1:0]       fill_dat_i,
    input  logic                inv_i,
    input  logic [idx_bits-1:0] inv_idx_i,
    input  logic [tag_w-1:0]    inv_tag_i,
    input  logic [idx_bits-1:0] rd_idx_i,
    output logic                rd_valid_o,
    output logic [tag_w-1:0]    rd_tag_o,
    output logic [dw-1:0]       rd_dat_o
);
    localparam int ENTRIES = 1 << idx_bits;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [tag_w-1:0]   tag_q  [ENTRIES];
    logic [dw-1:0]      data_q [ENTRIES];

    // Invalidate is applied first so a same-index fill overrides it.
    always_comb begin
        valid_d = valid_q;
        if (inv_i && (tag_q[inv_idx_i] == inv_tag_i)) begin
            valid_d[inv_idx_i] = 1'b0;
        end
        if (fill_we_i) begin
            valid_d[fill_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (fill_we_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_dat_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_dat_o   = data_q[rd_idx_i];
endmodule

// File: rtl/wb_snoop_responder.sv
// Per-core snoop responder. Answers read probes from the snoop arbiter with
// an ack, a hit flag and the line data out of a small direct-mapped copy of
// lines owned by the core.
// Ports:
//   wb_clk_i, wb_rst_i : clock, sync active-high reset
//   snp (slave)        : snoop bus slice (address, type, ack, hit, data)
//   fill_we_i/adr/dat  : core-side fill of an entry
//   inv_i/inv_adr_i    : core-side invalidate (only if tag matches)
//   snoop_hits_o       : saturating count of probes answered with a hit
module wb_snoop_responder
    import wb_snoop_responder_pkg::*;
#(
    parameter int aw       = 32,
    parameter int dw       = 32,
    parameter int idx_bits = 3
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_snoop_responder_if.slave  snp,
    input  logic                 fill_we_i,
    input  logic [aw-1:0]        fill_adr_i,
    input  logic [dw-1:0]        fill_dat_i,
    input  logic                 inv_i,
    input  logic [aw-1:0]        inv_adr_i,
    output logic [15:0]          snoop_hits_o
);
    localparam int TAG_W = aw - idx_bits - 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state_q, state_d;
    logic [aw-1:2]       adr_q, adr_d;
    logic                res_hit_q, res_hit_d;
    logic [dw-1:0]       res_dat_q, res_dat_d;
    logic                ack_q, ack_d;
    logic                vld_q, vld_d;
    logic [dw-1:0]       dat_q, dat_d;
    logic [15:0]         hits_q, hits_d;

    logic [idx_bits-1:0] lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [dw-1:0]       rd_dat;
    logic                fwd_fill, fwd_inv, lk_hit;
    logic [dw-1:0]       lk_dat;

    // Byte-offset bits carry no meaning for word-granular entries.
    logic [5:0] unused_adr_lsbs;
    assign unused_adr_lsbs = {fill_adr_i[1:0], inv_adr_i[1:0], snp.snoop_adr_i[1:0]};

    assign lk_idx = adr_q[idx_bits+1:2];
    assign lk_tag = adr_q[aw-1:idx_bits+2];

    wb_snoop_responder_tag_store #(
        .idx_bits (idx_bits),
        .tag_w    (TAG_W),
        .dw       (dw)
    ) u_store (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .fill_we_i  (fill_we_i),
        .fill_idx_i (fill_adr_i[idx_bits+1:2]),
        .fill_tag_i (fill_adr_i[aw-1:idx_bits+2]),
        .fill_dat_i (fill_dat_i),
        .inv_i      (inv_i),
        .inv_idx_i  (inv_adr_i[idx_bits+1:2]),
        .inv_tag_i  (inv_adr_i[aw-1:idx_bits+2]),
        .rd_idx_i   (lk_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_dat_o   (rd_dat)
    );

    // The store read reflects contents before this edge's fill/invalidate,
    // so same-cycle writes to the probed index are forwarded here.
    // A fill beats an invalidate to the same index.
    always_comb begin
        fwd_fill = fill_we_i && (fill_adr_i[idx_bits+1:2] == lk_idx);
        fwd_inv  = inv_i && (inv_adr_i[idx_bits+1:2] == lk_idx)
                         && (inv_adr_i[aw-1:idx_bits+2] == lk_tag);
        lk_dat   = rd_dat;
        if (fwd_fill) begin
            lk_hit = (fill_adr_i[aw-1:idx_bits+2] == lk_tag);
            lk_dat = fill_dat_i;
        end else if (fwd_inv) begin
            lk_hit = 1'b0;
        end else begin
            lk_hit = rd_valid && (rd_tag == lk_tag);
        end
    end

    // Outputs are registered: they only go high on an edge where RESPOND
    // still sees the probe asserted, and drop on the edge that sees it low.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        res_hit_d = res_hit_q;
        res_dat_d = res_dat_q;
        hits_d    = hits_q;
        ack_d     = 1'b0;
        vld_d     = 1'b0;
        dat_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (snp.snoop_type_i == SNOOP_TYPE_READ) begin
                    state_d = ST_LOOKUP;
                    adr_d   = snp.snoop_adr_i[aw-1:2];
                end
            end
            ST_LOOKUP: begin
                state_d   = ST_RESPOND;
                res_hit_d = lk_hit;
                res_dat_d = lk_hit ? lk_dat : '0;
                if (lk_hit) begin
                    hits_d = sat_inc16(hits_q);
                end
            end
            ST_RESPOND: begin
                if (snp.snoop_type_i == SNOOP_TYPE_IDLE) begin
                    state_d = ST_IDLE;
                end else begin
                    ack_d = 1'b1;
                    vld_d = res_hit_q;
                    dat_d = res_dat_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            hits_q  <= hits_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        adr_q     <= adr_d;
        res_hit_q <= res_hit_d;
        res_dat_q <= res_dat_d;
    end

    assign snp.snoop_ack_o       = ack_q;
    assign snp.snoop_valid_dat_o = vld_q;
    assign snp.snooped_dat_o     = dat_q;
    assign snoop_hits_o          = hits_q;
endmodule
